// File: rtl/rtc_pkg.sv
// Shared constants for the clock card reader: card register map, snapshot
// field layout, signature bytes, per-field digit limits and FSM states.
package rtc_pkg;

  // Card register offsets (device-select space)
  localparam int OFF_SIG0   = 0;
  localparam int OFF_SIG1   = 1;
  localparam int OFF_YEAR_T = 2;
  localparam int OFF_YEAR_O = 3;
  localparam int OFF_MON_T  = 4;
  localparam int OFF_MON_O  = 5;
  localparam int OFF_DOW    = 6;
  localparam int OFF_DAY_T  = 7;
  localparam int OFF_DAY_O  = 8;
  localparam int OFF_HR_T   = 9;
  localparam int OFF_HR_O   = 10;
  localparam int OFF_MIN_T  = 11;
  localparam int OFF_MIN_O  = 12;
  localparam int OFF_SEC_T  = 13;
  localparam int OFF_SEC_O  = 14;

  // Scan layout: 15 registers, then the seconds pair read a second time
  localparam int NUM_REGS     = 15;
  localparam int NUM_READS    = 17;
  localparam int REREAD_SEC_T = 15;
  localparam int REREAD_SEC_O = 16;

  // Snapshot vector layout
  localparam int RTC_W      = 65;
  localparam int TOGGLE_BIT = 64;
  localparam int SEC_O_LSB  = 0;   localparam int SEC_O_W  = 4;
  localparam int SEC_T_LSB  = 4;   localparam int SEC_T_W  = 3;
  localparam int MIN_O_LSB  = 8;   localparam int MIN_O_W  = 4;
  localparam int MIN_T_LSB  = 12;  localparam int MIN_T_W  = 3;
  localparam int HR_O_LSB   = 16;  localparam int HR_O_W   = 4;
  localparam int HR_T_LSB   = 20;  localparam int HR_T_W   = 2;
  localparam int DAY_O_LSB  = 24;  localparam int DAY_O_W  = 4;
  localparam int DAY_T_LSB  = 28;  localparam int DAY_T_W  = 2;
  localparam int MON_O_LSB  = 32;  localparam int MON_O_W  = 4;
  localparam int MON_T_LSB  = 36;  localparam int MON_T_W  = 1;
  localparam int YEAR_O_LSB = 40;  localparam int YEAR_O_W = 4;
  localparam int YEAR_T_LSB = 44;  localparam int YEAR_T_W = 4;
  localparam int DOW_LSB    = 48;  localparam int DOW_W    = 3;

  // Signature bytes the card presents at offsets 0 and 1
  localparam logic [7:0] SIG0_BYTE = 8'h32;
  localparam logic [7:0] SIG1_BYTE = 8'h30;

  // ASCII digit range and the largest digit allowed per tens field
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam int DIGIT_MAX  = 9;
  localparam int MON_T_MAX  = 1;
  localparam int DOW_MAX    = 6;
  localparam int DAY_T_MAX  = 3;
  localparam int HR_T_MAX   = 2;
  localparam int MIN_T_MAX  = 5;
  localparam int SEC_T_MAX  = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ADDR,
    ST_SAMPLE,
    ST_CHECK
  } state_t;

  // Largest legal digit value for the byte at a given register offset
  function automatic logic [7:0] field_max(input int off);
    case (off)
      OFF_MON_T: return 8'(MON_T_MAX);
      OFF_DOW:   return 8'(DOW_MAX);
      OFF_DAY_T: return 8'(DAY_T_MAX);
      OFF_HR_T:  return 8'(HR_T_MAX);
      OFF_MIN_T: return 8'(MIN_T_MAX);
      OFF_SEC_T: return 8'(SEC_T_MAX);
      default:   return 8'(DIGIT_MAX);
    endcase
  endfunction

  // Register offset visited at each step of the scan
  function automatic logic [3:0] seq_offset(input logic [4:0] idx);
    if (idx == 5'(REREAD_SEC_T))
      return 4'(OFF_SEC_T);
    else if (idx == 5'(REREAD_SEC_O))
      return 4'(OFF_SEC_O);
    else
      return idx[3:0];
  endfunction

endpackage

// File: rtl/rtc_field_check.sv
// Combinational validator: every captured card byte must carry the expected
// signature or an ASCII digit within the range of its field.
module rtc_field_check
  import rtc_pkg::*;
(
  input  logic [NUM_REGS-1:0][7:0] regs,
  output logic                     format_ok
);

  logic [NUM_REGS-1:0] byte_ok;

  assign byte_ok[OFF_SIG0] = (regs[OFF_SIG0] == SIG0_BYTE);
  assign byte_ok[OFF_SIG1] = (regs[OFF_SIG1] == SIG1_BYTE);

  // Each time/date byte is '0' up to '0' + the field's maximum digit
  genvar gi;
  generate
    for (gi = OFF_YEAR_T; gi < NUM_REGS; gi++) begin : g_digit
      assign byte_ok[gi] = (regs[gi] >= ASCII_ZERO) &&
                           (regs[gi] <= (ASCII_ZERO + field_max(gi)));
    end
  endgenerate

  assign format_ok = &byte_ok;

endmodule

// File: rtl/clock_card_reader.sv
// Slot-bus initiator that scans the clock card's BCD registers, confirms the
// seconds did not roll during the scan, validates the byte format and
// publishes a packed RTC snapshot whose top bit toggles on every update.
module clock_card_reader
  import rtc_pkg::*;
#(
  parameter int MAX_RETRY    = 3,
  parameter bit CHECK_FORMAT = 1'b1
)(
  input  logic             CLK_14M,
  input  logic             RESET,
  input  logic             BUS_CE,
  input  logic             START,
  output logic             BUS_REQ,
  input  logic             BUS_GNT,
  output logic [3:0]       ADDRESS,
  output logic             DEVICE_SELECT_N,
  output logic             RW_N,
  input  logic [7:0]       DATA_IN,
  output logic [RTC_W-1:0] RTC_OUT,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [4:0] LAST_INDEX = 5'(NUM_READS - 1);

  state_t                      state;
  logic [4:0]                  index;
  logic [RETRY_W-1:0]          retry_count;
  logic [NUM_READS-1:0][7:0]   slot;
  logic [RTC_W-2:0]            snapshot;
  logic                        format_ok;
  logic                        sec_mismatch;
  logic                        format_fail;
  logic                        retry_left;

  // The reader never writes the card
  assign RW_N = 1'b1;

  rtc_field_check u_field_check (
    .regs      (slot[NUM_REGS-1:0]),
    .format_ok (format_ok)
  );

  // A changed seconds byte means the card ticked mid-scan and fields may mix
  assign sec_mismatch = (slot[OFF_SEC_T] != slot[REREAD_SEC_T]) ||
                        (slot[OFF_SEC_O] != slot[REREAD_SEC_O]);
  assign format_fail  = CHECK_FORMAT && !format_ok;
  assign retry_left   = (int'(retry_count) < MAX_RETRY);

  // Repack the captured low nibbles into the card's 64-bit RTC layout
  always_comb begin
    snapshot = '0;
    snapshot[SEC_O_LSB  +: SEC_O_W ] = slot[OFF_SEC_O ][SEC_O_W-1:0];
    snapshot[SEC_T_LSB  +: SEC_T_W ] = slot[OFF_SEC_T ][SEC_T_W-1:0];
    snapshot[MIN_O_LSB  +: MIN_O_W ] = slot[OFF_MIN_O ][MIN_O_W-1:0];
    snapshot[MIN_T_LSB  +: MIN_T_W ] = slot[OFF_MIN_T ][MIN_T_W-1:0];
    snapshot[HR_O_LSB   +: HR_O_W  ] = slot[OFF_HR_O  ][HR_O_W-1:0];
    snapshot[HR_T_LSB   +: HR_T_W  ] = slot[OFF_HR_T  ][HR_T_W-1:0];
    snapshot[DAY_O_LSB  +: DAY_O_W ] = slot[OFF_DAY_O ][DAY_O_W-1:0];
    snapshot[DAY_T_LSB  +: DAY_T_W ] = slot[OFF_DAY_T ][DAY_T_W-1:0];
    snapshot[MON_O_LSB  +: MON_O_W ] = slot[OFF_MON_O ][MON_O_W-1:0];
    snapshot[MON_T_LSB  +: MON_T_W ] = slot[OFF_MON_T ][MON_T_W-1:0];
    snapshot[YEAR_O_LSB +: YEAR_O_W] = slot[OFF_YEAR_O][YEAR_O_W-1:0];
    snapshot[YEAR_T_LSB +: YEAR_T_W] = slot[OFF_YEAR_T][YEAR_T_W-1:0];
    snapshot[DOW_LSB    +: DOW_W   ] = slot[OFF_DOW   ][DOW_W-1:0];
  end

  // Scan sequencer: request bus, address/sample each register, then judge
  always_ff @(posedge CLK_14M or posedge RESET) begin
    if (RESET) begin
      state           <= ST_IDLE;
      index           <= '0;
      retry_count     <= '0;
      slot            <= '0;
      BUS_REQ         <= 1'b0;
      ADDRESS         <= '0;
      DEVICE_SELECT_N <= 1'b1;
      RTC_OUT         <= '0;
      BUSY            <= 1'b0;
      DONE            <= 1'b0;
      ERR             <= 1'b0;
    end else begin
      DONE <= 1'b0;
      ERR  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            BUSY        <= 1'b1;
            BUS_REQ     <= 1'b1;
            retry_count <= '0;
            index       <= '0;
            state       <= ST_REQ;
          end
        end

        ST_REQ: begin
          BUS_REQ         <= 1'b1;
          DEVICE_SELECT_N <= 1'b1;
          if (BUS_GNT)
            state <= ST_ADDR;
        end

        ST_ADDR: begin
          if (!BUS_GNT) begin
            // Grant lost: release the card and re-read this register later
            DEVICE_SELECT_N <= 1'b1;
            state           <= ST_REQ;
          end else begin
            ADDRESS         <= seq_offset(index);
            DEVICE_SELECT_N <= 1'b0;
            if (BUS_CE)
              state <= ST_SAMPLE;
          end
        end

        ST_SAMPLE: begin
          if (!BUS_GNT) begin
            DEVICE_SELECT_N <= 1'b1;
            state           <= ST_REQ;
          end else if (BUS_CE) begin
            slot[index]     <= DATA_IN;
            // One idle select cycle separates consecutive register reads
            DEVICE_SELECT_N <= 1'b1;
            index           <= index + 5'd1;
            if (index == LAST_INDEX)
              state <= ST_CHECK;
            else
              state <= ST_ADDR;
          end
        end

        ST_CHECK: begin
          if (sec_mismatch && retry_left) begin
            // Rescan from the top while keeping the bus
            retry_count <= retry_count + RETRY_W'(1);
            index       <= '0;
            state       <= ST_ADDR;
          end else begin
            if (sec_mismatch || format_fail) begin
              ERR <= 1'b1;
            end else begin
              RTC_OUT <= {~RTC_OUT[TOGGLE_BIT], snapshot};
              DONE    <= 1'b1;
            end
            BUS_REQ <= 1'b0;
            BUSY    <= 1'b0;
            state   <= ST_IDLE;
          end
        end

        default: begin
          BUS_REQ         <= 1'b0;
          DEVICE_SELECT_N <= 1'b1;
          BUSY            <= 1'b0;
          state           <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_card_reader.sv
// Directed bench for clock_card_reader: a card model answers reads from a
// register array; one instance validates format, a second one does not.
`timescale 1ns/1ps
module tb_clock_card_reader;

  localparam logic [63:0] T_BASE  = 64'h0005_2403_1513_4722;
  localparam logic [63:0] T_SEC23 = 64'h0005_2403_1513_4723;
  localparam logic [63:0] T_MIN_A = 64'h0005_2403_1513_4A22;

  logic        clk;
  logic        rst;
  logic        bus_ce;
  logic        start;
  logic        bus_gnt;
  logic        bus_req, dsn, rw_n, busy, done, err;
  logic [3:0]  address;
  logic [7:0]  data_in;
  logic [64:0] rtc_out;
  logic        bus_req_nf, dsn_nf, rw_n_nf, busy_nf, done_nf, err_nf;
  logic [3:0]  address_nf;
  logic [7:0]  data_in_nf;
  logic [64:0] rtc_out_nf;

  logic [7:0]  card [16];
  logic [7:0]  sec_bump;
  int          bump_mode;
  int          bump_limit;

  int tests_run = 0;
  int tests_failed = 0;

  // monitor state
  int cyc = 0, ce_total = 0, last_ce_cyc = 0;
  int done_cnt = 0, err_cnt = 0, req_gap = 0;
  logic [3:0] prev_addr = 4'h0;

  int ce0, d0, n, gap, bad, gap0;

  clock_card_reader #(.MAX_RETRY(3), .CHECK_FORMAT(1'b1)) dut (
    .CLK_14M(clk), .RESET(rst), .BUS_CE(bus_ce), .START(start),
    .BUS_REQ(bus_req), .BUS_GNT(bus_gnt), .ADDRESS(address),
    .DEVICE_SELECT_N(dsn), .RW_N(rw_n), .DATA_IN(data_in),
    .RTC_OUT(rtc_out), .BUSY(busy), .DONE(done), .ERR(err)
  );

  clock_card_reader #(.MAX_RETRY(3), .CHECK_FORMAT(1'b0)) dut_nf (
    .CLK_14M(clk), .RESET(rst), .BUS_CE(bus_ce), .START(start),
    .BUS_REQ(bus_req_nf), .BUS_GNT(bus_gnt), .ADDRESS(address_nf),
    .DEVICE_SELECT_N(dsn_nf), .RW_N(rw_n_nf), .DATA_IN(data_in_nf),
    .RTC_OUT(rtc_out_nf), .BUSY(busy_nf), .DONE(done_nf), .ERR(err_nf)
  );

  // Card model: combinational read, seconds-ones optionally bumped
  assign data_in    = card[address]    + ((address    == 4'hE) ? sec_bump : 8'h00);
  assign data_in_nf = card[address_nf] + ((address_nf == 4'hE) ? sec_bump : 8'h00);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bus strobe: one cycle high out of every four
  initial begin
    int ce_div;
    ce_div = 0;
    bus_ce = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus_ce = (ce_div == 3);
      ce_div = (ce_div + 1) % 4;
    end
  end

  // Observe strobes, completions and bus-request holes on the falling edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus_ce) begin ce_total = ce_total + 1; last_ce_cyc = cyc; end
    if (done) done_cnt = done_cnt + 1;
    if (err) err_cnt = err_cnt + 1;
    if (busy && !bus_req) req_gap = req_gap + 1;
  end

  // Seconds roll model: bump between the first seconds read and its re-read
  always @(negedge clk) begin
    if (bump_mode == 0)
      sec_bump = 8'h00;
    else if (prev_addr == 4'hE && address == 4'hD && int'(sec_bump) < bump_limit)
      sec_bump = sec_bump + 8'h01;
    prev_addr = address;
  end

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    tests_run = tests_run + 1;
    if (got !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load_card();
    card[0]  = 8'h32; card[1]  = 8'h30; card[2]  = 8'h32; card[3]  = 8'h34;
    card[4]  = 8'h30; card[5]  = 8'h33; card[6]  = 8'h35; card[7]  = 8'h31;
    card[8]  = 8'h35; card[9]  = 8'h31; card[10] = 8'h33; card[11] = 8'h34;
    card[12] = 8'h37; card[13] = 8'h32; card[14] = 8'h32; card[15] = 8'h00;
  endtask

  // Pulse START in the cycle right after a strobe and note the strobe count
  task automatic do_start();
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (!bus_ce && k < 20);
    @(posedge clk);
    #1;
    ce0 = ce_total;
    d0 = done_cnt;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (!(done || err) && k < 3000);
    #1;
    check({tag, "_end"}, 65'(done | err), 65'(1));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bus_gnt = 1'b1;
    bump_mode = 0; bump_limit = 0;
    load_card();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req",  65'(bus_req), 65'(0));
    check("rst_addr", 65'(address), 65'(0));
    check("rst_dsn",  65'(dsn),     65'(1));
    check("rst_rw",   65'(rw_n),    65'(1));
    check("rst_rtc",  rtc_out,      65'(0));
    check("rst_busy", 65'({busy, done, err}), 65'(0));
    rst = 1'b0;
    repeat (4) @(posedge clk);

    // 1a: plain snapshot, grant held
    do_start();
    wait_end("t1a");
    check("t1a_done", 65'(done), 65'(1));
    check("t1a_ce",   65'(ce_total - ce0), 65'(34));
    check("t1a_lat",  65'(cyc - last_ce_cyc), 65'(2));
    check("t1a_rtc",  rtc_out, {1'b1, T_BASE});
    check("t1a_req",  65'({bus_req, busy}), 65'(0));
    $display("[TB] t1a snapshot rtc=%h", rtc_out);

    // 1b: second snapshot flips bit 64; START while busy is ignored
    do_start();
    repeat (40) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_end("t1b");
    check("t1b_ce",  65'(ce_total - ce0), 65'(34));
    check("t1b_rtc", rtc_out, {1'b0, T_BASE});
    repeat (150) @(posedge clk);
    check("t1b_once", 65'(done_cnt - d0), 65'(1));
    $display("[TB] t1b snapshot rtc=%h", rtc_out);

    // 2: seconds roll once -> one rescan, bus held
    gap0 = req_gap;
    bump_mode = 1; bump_limit = 1;
    do_start();
    wait_end("t2");
    check("t2_done", 65'(done), 65'(1));
    check("t2_ce",   65'(ce_total - ce0), 65'(68));
    check("t2_rtc",  rtc_out, {1'b1, T_SEC23});
    check("t2_hold", 65'(req_gap - gap0), 65'(0));
    bump_mode = 0;
    repeat (4) @(posedge clk);
    $display("[TB] t2 rescan rtc=%h", rtc_out);

    // 3: seconds change every scan -> 4 scans then ERR
    bump_mode = 2; bump_limit = 100;
    do_start();
    wait_end("t3");
    check("t3_err", 65'({err, done}), 65'(2));
    check("t3_ce",  65'(ce_total - ce0), 65'(136));
    check("t3_rtc", rtc_out, {1'b1, T_SEC23});
    check("t3_req", 65'({bus_req, busy}), 65'(0));
    bump_mode = 0;
    repeat (4) @(posedge clk);
    $display("[TB] t3 retries exhausted err=%0d", err_cnt);

    // 4: bad minute digit -> ERR with format check, DONE without
    card[12] = 8'h3A;
    do_start();
    wait_end("t4");
    check("t4_err",    65'({err, done}), 65'(2));
    check("t4_ce",     65'(ce_total - ce0), 65'(34));
    check("t4_rtc",    rtc_out, {1'b1, T_SEC23});
    check("t4_nfdone", 65'({done_nf, err_nf}), 65'(2));
    check("t4_nfrtc",  rtc_out_nf, {1'b0, T_MIN_A});
    load_card();
    $display("[TB] t4 format reject, unchecked rtc=%h", rtc_out_nf);

    // 5: grant lost for 5 strobes while sampling offset 7
    do_start();
    n = 0;
    do begin @(negedge clk); n++; end while (!(address == 4'h7 && dsn == 1'b0 && bus_ce) && n < 2000);
    check("t5_reach", 65'(address), 65'(7));
    @(posedge clk);
    #1 bus_gnt = 1'b0;
    @(negedge clk);
    gap = 0; bad = 0;
    while (gap < 5) begin
      @(negedge clk);
      if (dsn !== 1'b1) bad++;
      if (bus_ce) gap++;
    end
    check("t5_dsn_gap", 65'(bad), 65'(0));
    @(posedge clk);
    #1 bus_gnt = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (dsn !== 1'b0 && n < 100);
    check("t5_reread", 65'(address), 65'(7));
    wait_end("t5");
    check("t5_ce",  65'(ce_total - ce0), 65'(40));
    check("t5_rtc", rtc_out, {1'b0, T_BASE});
    $display("[TB] t5 grant gap rtc=%h", rtc_out);

    // 6: reset mid-scan at index 9, then a clean snapshot
    do_start();
    n = 0;
    do begin @(negedge clk); n++; end while (!(address == 4'h9 && dsn == 1'b0) && n < 2000);
    #2 rst = 1'b1;
    #1;
    check("t6_req",  65'(bus_req), 65'(0));
    check("t6_addr", 65'(address), 65'(0));
    check("t6_dsn",  65'(dsn),     65'(1));
    check("t6_rtc",  rtc_out,      65'(0));
    check("t6_busy", 65'({busy, done, err, rw_n}), 65'(1));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    do_start();
    wait_end("t6");
    check("t6_ce",     65'(ce_total - ce0), 65'(34));
    check("t6_rtcnew", rtc_out, {1'b1, T_BASE});
    $display("[TB] t6 after reset rtc=%h", rtc_out);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
